// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - registered RV32I ALU control decoder with shift and optional mul/div sequencing (ALU_CTRL_MULDIV_EN)
module alu_control_seq #(
    parameter int OP_WIDTH      = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int SHIFT_STEP    = 1,
    parameter int MULDIV_CYCLES = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [6:0]                    funct7_i,
    input  logic [2:0]                    ALU_Op_i,
    input  logic [2:0]                    funct3_i,
    input  logic [$clog2(DATA_WIDTH)-1:0] shamt_i,
    output logic [OP_WIDTH-1:0]           ALU_Operation_o,
    output logic [$clog2(DATA_WIDTH)-1:0] step_amt_o,
    output logic                          op_valid_o,
    output logic                          last_o,
    output logic                          stall_o,
    output logic                          illegal_o
);

    localparam int SW = $clog2(DATA_WIDTH);
    localparam logic [31:0] STEP_U = 32'(SHIFT_STEP);

    localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(4'b0000);
    localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(4'b0001);
    localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(4'b0010);
    localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(4'b0011);
    localparam logic [OP_WIDTH-1:0] OP_SLL  = OP_WIDTH'(4'b0100);
    localparam logic [OP_WIDTH-1:0] OP_SRL  = OP_WIDTH'(4'b0101);
    localparam logic [OP_WIDTH-1:0] OP_SLT  = OP_WIDTH'(4'b0110);
    localparam logic [OP_WIDTH-1:0] OP_SLTU = OP_WIDTH'(4'b0111);
    localparam logic [OP_WIDTH-1:0] OP_LUI  = OP_WIDTH'(4'b1000);
    localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(4'b1001);
    localparam logic [OP_WIDTH-1:0] OP_SRA  = OP_WIDTH'(4'b1010);
    localparam logic [OP_WIDTH-1:0] OP_NOP  = OP_WIDTH'(4'b1111);

`ifdef ALU_CTRL_MULDIV_EN
    localparam logic [OP_WIDTH-1:0] OP_MUL  = OP_WIDTH'(4'b1011);
    localparam logic [OP_WIDTH-1:0] OP_MULH = OP_WIDTH'(4'b1100);
    localparam logic [OP_WIDTH-1:0] OP_DIV  = OP_WIDTH'(4'b1101);
    localparam logic [OP_WIDTH-1:0] OP_REM  = OP_WIDTH'(4'b1110);
    localparam int CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MULDIV_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SHIFT, S_MULDIV} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SHIFT} state_t;
`endif

    state_t              r_state;
    state_t              w_state_nx;
    logic [SW-1:0]       r_rem;
    logic [SW-1:0]       w_rem_nx;
    logic [OP_WIDTH-1:0] r_op;
    logic [OP_WIDTH-1:0] w_op_nx;
    logic [SW-1:0]       r_step;
    logic [SW-1:0]       w_step_nx;
    logic                r_valid;
    logic                w_valid_nx;
    logic                r_last;
    logic                w_last_nx;
    logic                r_stall;
    logic                w_stall_nx;
    logic                r_illegal;
    logic                w_illegal_nx;
    logic [SW-1:0]       w_step_now;
    logic [SW-1:0]       w_left;

    logic                w_dec_ok;
    logic                w_dec_shift;
    logic [OP_WIDTH-1:0] w_dec_op;
    logic                w_f7_base;
`ifdef ALU_CTRL_MULDIV_EN
    logic                w_dec_md;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nx;
`endif

    // Shift issue width for this cycle: never more than what is left to shift
    function automatic logic [SW-1:0] f_step(input logic [SW-1:0] rem);
        if (32'(rem) > STEP_U) begin
            return SW'(STEP_U);
        end
        return rem;
    endfunction

    assign w_f7_base = (funct7_i == 7'b0000000) || (funct7_i == 7'b0100000);

    // Decode {funct7, ALU_Op, funct3} into an op code plus legality and sequencing class
    always_comb begin
        w_dec_ok    = 1'b1;
        w_dec_op    = OP_NOP;
        w_dec_shift = 1'b0;
`ifdef ALU_CTRL_MULDIV_EN
        w_dec_md    = 1'b0;
`endif
        case (ALU_Op_i)
            3'b000: begin
                if (funct7_i == 7'b0000001) begin
`ifdef ALU_CTRL_MULDIV_EN
                    w_dec_md = 1'b1;
                    case (funct3_i)
                        3'd0:             w_dec_op = OP_MUL;
                        3'd1, 3'd2, 3'd3: w_dec_op = OP_MULH;
                        3'd4, 3'd5:       w_dec_op = OP_DIV;
                        default:          w_dec_op = OP_REM;
                    endcase
`else
                    w_dec_ok = 1'b0;
`endif
                end else if (!w_f7_base) begin
                    w_dec_ok = 1'b0;
                end else begin
                    case (funct3_i)
                        3'd0:    w_dec_op = funct7_i[5] ? OP_SUB : OP_ADD;
                        3'd1:    w_dec_op = OP_SLL;
                        3'd2:    w_dec_op = OP_SLT;
                        3'd3:    w_dec_op = OP_SLTU;
                        3'd4:    w_dec_op = OP_XOR;
                        3'd5:    w_dec_op = funct7_i[5] ? OP_SRA : OP_SRL;
                        3'd6:    w_dec_op = OP_OR;
                        default: w_dec_op = OP_AND;
                    endcase
                    if (funct7_i[5] && (funct3_i != 3'd0) && (funct3_i != 3'd5)) begin
                        w_dec_ok = 1'b0;
                    end
                end
            end
            3'b001: begin
                case (funct3_i)
                    3'd0:    w_dec_op = OP_ADD;
                    3'd1:    begin w_dec_op = OP_SLL; w_dec_ok = w_f7_base; end
                    3'd2:    w_dec_op = OP_SLT;
                    3'd3:    w_dec_op = OP_SLTU;
                    3'd4:    w_dec_op = OP_XOR;
                    3'd5:    begin w_dec_op = funct7_i[5] ? OP_SRA : OP_SRL; w_dec_ok = w_f7_base; end
                    3'd6:    w_dec_op = OP_OR;
                    default: w_dec_op = OP_AND;
                endcase
            end
            3'b010:         w_dec_op = OP_LUI;
            3'b011, 3'b101: w_dec_op = OP_ADD;
            3'b100: begin
                case (funct3_i)
                    3'd0, 3'd1: w_dec_op = OP_SUB;
                    3'd4, 3'd5: w_dec_op = OP_SLT;
                    3'd6, 3'd7: w_dec_op = OP_SLTU;
                    default:    w_dec_ok = 1'b0;
                endcase
            end
            default: w_dec_ok = 1'b0;
        endcase
        w_dec_shift = (w_dec_op == OP_SLL) || (w_dec_op == OP_SRL) || (w_dec_op == OP_SRA);
    end

    // Next state and next registered outputs; idle cycles present NOP with everything low
    always_comb begin
        w_state_nx   = r_state;
        w_rem_nx     = r_rem;
        w_op_nx      = OP_NOP;
        w_step_nx    = '0;
        w_valid_nx   = 1'b0;
        w_last_nx    = 1'b0;
        w_stall_nx   = 1'b0;
        w_illegal_nx = 1'b0;
        w_step_now   = '0;
        w_left       = '0;
`ifdef ALU_CTRL_MULDIV_EN
        w_cnt_nx     = r_cnt;
`endif
        case (r_state)
            S_SHIFT: begin
                if (r_rem == '0) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_step_now = f_step(r_rem);
                    w_left     = r_rem - w_step_now;
                    w_rem_nx   = w_left;
                    w_op_nx    = r_op;
                    w_step_nx  = w_step_now;
                    w_valid_nx = 1'b1;
                    w_last_nx  = (w_left == '0);
                    w_stall_nx = (w_left != '0);
                end
            end
`ifdef ALU_CTRL_MULDIV_EN
            S_MULDIV: begin
                if (r_cnt == '0) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx   = r_cnt - 1'b1;
                    w_op_nx    = r_op;
                    w_valid_nx = 1'b1;
                    w_last_nx  = (w_cnt_nx == '0);
                    w_stall_nx = (w_cnt_nx != '0);
                end
            end
`endif
            default: begin
                // IDLE and ISSUE both accept, giving one single-cycle result per clock
                w_state_nx = S_IDLE;
                if (valid_i) begin
                    if (!w_dec_ok) begin
                        w_illegal_nx = 1'b1;
                    end else if (w_dec_shift) begin
                        w_step_now = f_step(shamt_i);
                        w_left     = shamt_i - w_step_now;
                        w_rem_nx   = w_left;
                        w_op_nx    = w_dec_op;
                        w_step_nx  = w_step_now;
                        w_valid_nx = 1'b1;
                        w_last_nx  = (w_left == '0);
                        w_stall_nx = (w_left != '0);
                        w_state_nx = S_SHIFT;
`ifdef ALU_CTRL_MULDIV_EN
                    end else if (w_dec_md) begin
                        w_cnt_nx   = CNT_LOAD;
                        w_op_nx    = w_dec_op;
                        w_valid_nx = 1'b1;
                        w_last_nx  = (CNT_LOAD == '0);
                        w_stall_nx = (CNT_LOAD != '0);
                        w_state_nx = S_MULDIV;
`endif
                    end else begin
                        w_op_nx    = w_dec_op;
                        w_valid_nx = 1'b1;
                        w_last_nx  = 1'b1;
                        w_state_nx = S_ISSUE;
                    end
                end
            end
        endcase
    end

    // State and output registers; reset aborts any sequence in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rem     <= '0;
            r_op      <= OP_NOP;
            r_step    <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_stall   <= 1'b0;
            r_illegal <= 1'b0;
`ifdef ALU_CTRL_MULDIV_EN
            r_cnt     <= '0;
`endif
        end else begin
            r_state   <= w_state_nx;
            r_rem     <= w_rem_nx;
            r_op      <= w_op_nx;
            r_step    <= w_step_nx;
            r_valid   <= w_valid_nx;
            r_last    <= w_last_nx;
            r_stall   <= w_stall_nx;
            r_illegal <= w_illegal_nx;
`ifdef ALU_CTRL_MULDIV_EN
            r_cnt     <= w_cnt_nx;
`endif
        end
    end

    assign ready_o         = (r_state == S_IDLE) || (r_state == S_ISSUE);
    assign ALU_Operation_o = r_op;
    assign step_amt_o      = r_step;
    assign op_valid_o      = r_valid;
    assign last_o          = r_last;
    assign stall_o         = r_stall;
    assign illegal_o       = r_illegal;

endmodule

// File: tb/tb_alu_control_seq.sv
// tb/tb_alu_control_seq.sv - directed and randomized checks of alu_control_seq against a beat-queue model
`timescale 1ns/1ps
module tb_alu_control_seq;

    localparam int STEP = 4;
    localparam int MDC  = 32;
    localparam logic [31:0] RTAB  = {4'h2, 4'h9, 4'h5, 4'h3, 4'h7, 4'h6, 4'h4, 4'h0};
    localparam logic [31:0] BTAB  = {4'h7, 4'h7, 4'h6, 4'h6, 4'hF, 4'hF, 4'h1, 4'h1};
    localparam logic [31:0] MDTAB = {4'hE, 4'hE, 4'hD, 4'hD, 4'hC, 4'hC, 4'hC, 4'hB};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [6:0] funct7_i = '0;
    logic [2:0] ALU_Op_i = '0;
    logic [2:0] funct3_i = '0;
    logic [4:0] shamt_i = '0;
    logic [3:0] ALU_Operation_o;
    logic [4:0] step_amt_o;
    logic       op_valid_o, last_o, stall_o, illegal_o;

    always #5 clk = ~clk;

    alu_control_seq #(
        .OP_WIDTH(4), .DATA_WIDTH(32), .SHIFT_STEP(STEP), .MULDIV_CYCLES(MDC)
    ) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
        .funct7_i(funct7_i), .ALU_Op_i(ALU_Op_i), .funct3_i(funct3_i), .shamt_i(shamt_i),
        .ALU_Operation_o(ALU_Operation_o), .step_amt_o(step_amt_o), .op_valid_o(op_valid_o),
        .last_o(last_o), .stall_o(stall_o), .illegal_o(illegal_o)
    );

    typedef struct packed {
        logic       blk;
        logic [3:0] op;
        logic [4:0] step;
        logic       v;
        logic       l;
        logic       s;
        logic       ill;
    } beat_t;

    beat_t cur;
    beat_t pend[$];
    int    n_total = 0;
    int    n_pass = 0;
    int    n_accept = 0;

    function automatic beat_t mk(logic blk, logic [3:0] op, logic [4:0] st, logic v, logic l, logic s, logic ill);
        beat_t b;
        b.blk = blk; b.op = op; b.step = st; b.v = v; b.l = l; b.s = s; b.ill = ill;
        return b;
    endfunction

    function automatic void ref_decode(input logic [6:0] f7, input logic [2:0] aop, input logic [2:0] f3,
                                       output bit ok, output logic [3:0] code, output bit md);
        bit std;
        std  = (f7 == 7'h00) || (f7 == 7'h20);
        ok   = 1'b1;
        md   = 1'b0;
        code = 4'hF;
        case (aop)
            3'd0: begin
                if (f7 == 7'h01) begin
`ifdef ALU_CTRL_MULDIV_EN
                    md   = 1'b1;
                    code = MDTAB[int'(f3)*4 +: 4];
`else
                    ok   = 1'b0;
`endif
                end else begin
                    ok   = std && (f7 == 7'h00 || f3 == 3'd0 || f3 == 3'd5);
                    code = RTAB[int'(f3)*4 +: 4];
                    if (f7 == 7'h20 && f3 == 3'd0) code = 4'h1;
                    if (f7 == 7'h20 && f3 == 3'd5) code = 4'hA;
                end
            end
            3'd1: begin
                code = RTAB[int'(f3)*4 +: 4];
                if (f3 == 3'd1 || f3 == 3'd5) ok = std;
                if (f3 == 3'd5 && f7[5]) code = 4'hA;
            end
            3'd2:       code = 4'h8;
            3'd3, 3'd5: code = 4'h0;
            3'd4: begin
                code = BTAB[int'(f3)*4 +: 4];
                ok   = (code != 4'hF);
            end
            default: ok = 1'b0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_edge();
        bit ok, md;
        logic [3:0] code;
        int n, rem, st;
        if (reset) begin
            cur = mk(0, 4'hF, 0, 0, 0, 0, 0);
            pend.delete();
        end else if (!cur.blk && valid_i) begin
            n_accept++;
            ref_decode(funct7_i, ALU_Op_i, funct3_i, ok, code, md);
            if (!ok) begin
                cur = mk(0, 4'hF, 0, 0, 0, 0, 1);
            end else if (code == 4'h4 || code == 4'h5 || code == 4'hA) begin
                n = (shamt_i == 0) ? 1 : (int'(shamt_i) + STEP - 1) / STEP;
                for (int i = 0; i < n; i++) begin
                    rem = int'(shamt_i) - i * STEP;
                    st  = (rem > STEP) ? STEP : rem;
                    pend.push_back(mk(1, code, 5'(st), 1, i == n - 1, i != n - 1, 0));
                end
                cur = pend.pop_front();
            end else if (md) begin
                for (int i = 0; i < MDC; i++) pend.push_back(mk(1, code, 0, 1, i == MDC - 1, i != MDC - 1, 0));
                cur = pend.pop_front();
            end else begin
                cur = mk(0, code, 0, 1, 1, 0, 0);
            end
        end else if (pend.size() > 0) begin
            cur = pend.pop_front();
        end else begin
            cur = mk(0, 4'hF, 0, 0, 0, 0, 0);
        end
    endtask

    function automatic logic [31:0] obs();
        return 32'({ready_o, ALU_Operation_o, step_amt_o, op_valid_o, last_o, stall_o, illegal_o});
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got %0h exp %0h", tag, got, exp);
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk(tag, obs(), 32'({~cur.blk, cur.op, cur.step, cur.v, cur.l, cur.s, cur.ill}));
    endtask

    task automatic set(logic v, logic [6:0] f7, logic [2:0] aop, logic [2:0] f3, logic [4:0] sh);
        valid_i = v; funct7_i = f7; ALU_Op_i = aop; funct3_i = f3; shamt_i = sh;
    endtask

    initial begin
        int   n_st, last_at, n_code, cyc, acc_goal, tries;
        bit   ok, md;
        logic [3:0] code;
        logic [6:0] f7;
        logic [2:0] aop, f3;

        cur = mk(0, 4'hF, 0, 0, 0, 0, 0);
        tick("rst0");
        tick("rst1");
        chk("rst_vals", obs(), 32'({1'b1, 4'hF, 5'd0, 4'b0000}));
        reset = 1'b0;
        tick("idle0");

        // back-to-back SUB, ADDI, LUI
        set(1, 7'h20, 3'd0, 3'd0, 5'd0); tick("t2_sub");
        chk("t2_sub_code", 32'({ALU_Operation_o, last_o, stall_o}), 32'({4'h1, 2'b10}));
        set(1, 7'h00, 3'd1, 3'd0, 5'd0); tick("t2_addi");
        chk("t2_addi_code", 32'({ALU_Operation_o, last_o, stall_o}), 32'({4'h0, 2'b10}));
        set(1, 7'h00, 3'd2, 3'd0, 5'd0); tick("t2_lui");
        chk("t2_lui_code", 32'({ALU_Operation_o, last_o, stall_o}), 32'({4'h8, 2'b10}));
        set(0, 7'h00, 3'd0, 3'd0, 5'd0); tick("t2_idle");

        // SRAI shamt 9 with valid held high throughout
        set(1, 7'h20, 3'd1, 3'd5, 5'd9); tick("t3_b1");
        chk("t3_b1_v", 32'({ALU_Operation_o, step_amt_o, stall_o, last_o, ready_o}), 32'({4'hA, 5'd4, 3'b100}));
        tick("t3_b2");
        chk("t3_b2_v", 32'({ALU_Operation_o, step_amt_o, stall_o, last_o, ready_o}), 32'({4'hA, 5'd4, 3'b100}));
        tick("t3_b3");
        chk("t3_b3_v", 32'({ALU_Operation_o, step_amt_o, stall_o, last_o, ready_o}), 32'({4'hA, 5'd1, 3'b010}));
        valid_i = 1'b0;
        tick("t3_end");
        chk("t3_end_v", 32'(op_valid_o), 32'd0);

        // reset in the middle of SLL shamt 9
        set(1, 7'h00, 3'd0, 3'd1, 5'd9); tick("t1_b1");
        chk("t1_b1_v", 32'({ALU_Operation_o, step_amt_o, stall_o}), 32'({4'h4, 5'd4, 1'b1}));
        valid_i = 1'b0;
        reset = 1'b1;
        tick("t1_rst");
        chk("t1_rst_vals", obs(), 32'({1'b1, 4'hF, 5'd0, 4'b0000}));
        reset = 1'b0;
        tick("t1_after");
        chk("t1_after_v", 32'({op_valid_o, last_o, stall_o}), 32'd0);

        // zero shift, branch decode, illegal branch
        set(1, 7'h00, 3'd0, 3'd1, 5'd0); tick("t4_sll0");
        chk("t4_sll0_v", 32'({ALU_Operation_o, step_amt_o, op_valid_o, last_o, stall_o}), 32'({4'h4, 5'd0, 3'b110}));
        set(0, 7'h00, 3'd0, 3'd0, 5'd0); tick("t4_gap");
        set(1, 7'h00, 3'd4, 3'd6, 5'd0); tick("t4_bltu");
        chk("t4_bltu_code", 32'(ALU_Operation_o), 32'h7);
        set(1, 7'h00, 3'd4, 3'd2, 5'd0); tick("t4_bill");
        chk("t4_bill_v", 32'({illegal_o, ALU_Operation_o, op_valid_o}), 32'({1'b1, 4'hF, 1'b0}));

        // illegal ALU_Op and funct7 = 0000001
        set(1, 7'h00, 3'd6, 3'd0, 5'd0); tick("t5_aop6");
        chk("t5_aop6_ill", 32'(illegal_o), 32'd1);
        set(1, 7'h01, 3'd0, 3'd4, 5'd0); tick("t5_m");
`ifdef ALU_CTRL_MULDIV_EN
        valid_i = 1'b0;
        n_st = 0; last_at = 0; n_code = 0;
        for (int i = 1; i <= MDC; i++) begin
            if (i > 1) tick("t5_div");
            if (stall_o) n_st++;
            if (last_o && last_at == 0) last_at = i;
            if (ALU_Operation_o == 4'hD && op_valid_o) n_code++;
        end
        chk("t5_div_stall", 32'(n_st), 32'(MDC - 1));
        chk("t5_div_last", 32'(last_at), 32'(MDC));
        chk("t5_div_code", 32'(n_code), 32'(MDC));
`else
        chk("t5_m_ill", 32'({illegal_o, ALU_Operation_o, op_valid_o}), 32'({1'b1, 4'hF, 1'b0}));
`endif
        set(0, 7'h00, 3'd0, 3'd0, 5'd0); tick("t5_idle");
        tick("t5_idle2");

        // random legal selectors
        acc_goal = n_accept + 10000;
        cyc = 0;
        while (n_accept < acc_goal && cyc < 60000) begin
            tries = 0;
            do begin
                aop = 3'($urandom_range(0, 5));
                case ($urandom_range(0, 3))
                    0:       f7 = 7'h00;
                    1:       f7 = 7'h20;
                    2:       f7 = 7'h01;
                    default: f7 = 7'($urandom);
                endcase
                f3 = 3'($urandom);
                ref_decode(f7, aop, f3, ok, code, md);
                tries++;
            end while (!ok && tries < 100);
            set(($urandom_range(0, 4) != 0), f7, aop, f3, 5'($urandom));
            tick("rand");
            cyc++;
        end
        chk("rand_accepts", 32'(n_accept), 32'(acc_goal));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
